// File: rtl/bus_pkg.sv
// Shared types and constants for the 8088 bus cycle master.
// Bus payload widths are fixed here; the top casts to its own ADDR_W/DATA_W.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 20;
  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned GAP_CNT_W  = 3;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

  typedef enum logic [6:0] {
    IDLE = 7'b000_0001,
    T1   = 7'b000_0010,
    T2   = 7'b000_0100,
    T3   = 7'b000_1000,
    TW   = 7'b001_0000,
    T4   = 7'b010_0000,
    GAP  = 7'b100_0000
  } bus_state_t;

  typedef struct packed {
    logic                  write;
    logic                  io;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for TW cycles; flags the last permitted wait cycle.
// timeout_c is high in the MAX_WAIT-th consecutive TW cycle.
module bus_wait_timer
  import bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic timeout_c
);

  localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q;

  // Counts completed TW cycles; cleared whenever the FSM is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + WAIT_CNT_W'(1);
    end
  end

  assign timeout_c = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/bus_cycle_master.sv
// 8088 bus cycle generator: T1-T2-T3-(TW)-T4 with valid/ready request side.
// Optional macro WAIT_STATE_EN enables READY-driven wait states and timeout.
module bus_cycle_master
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned IDLE_GAP = 0,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_io,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              READY,
  output logic              ALE,
  output logic              IOM,
  output logic              RD_N,
  output logic              WR_N,
  output logic              DEN_N,
  output logic              DTR,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(IDLE_GAP - 1);
  localparam logic                 B2B_EN   = (IDLE_GAP == 0);

  bus_state_t             state_q, state_d;
  bus_req_t               req_q, req_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic                   drive_q, drive_d;
  logic                   accept_c, capture_c, err_c, strobe_c;
  logic                   ws_ready_c, timeout_c;
  logic                   req_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0]      rsp_rdata_d;
  logic                   ale_d, iom_d, rd_n_d, wr_n_d, den_n_d, dtr_d;
  logic [ADDR_W-1:0]      address_d;

`ifdef WAIT_STATE_EN
  logic wait_clr, wait_inc;

  assign ws_ready_c = READY;
  assign wait_clr   = (state_q != TW);
  assign wait_inc   = (state_q == TW);

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .clr       (wait_clr),
    .inc       (wait_inc),
    .timeout_c (timeout_c)
  );
`else
  logic unused_ok;

  assign ws_ready_c = 1'b1;
  assign timeout_c  = 1'b0;
  assign unused_ok  = READY | (MAX_WAIT == 0);
`endif

  // Next state plus next value of every registered bus/response output.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    req_d     = req_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    err_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept_c = 1'b1;
          state_d  = T1;
        end
      end
      T1: state_d = T2;
      T2: state_d = T3;
      T3, TW: begin
        if (ws_ready_c) begin
          capture_c = !req_q.write;
          state_d   = T4;
        end else if (state_q == TW && timeout_c) begin
          err_c   = 1'b1;
          state_d = T4;
        end else begin
          state_d = TW;
        end
      end
      T4: begin
        if (!B2B_EN) begin
          gap_d   = '0;
          state_d = GAP;
        end else if (req_valid && req_ready) begin
          accept_c = 1'b1;
          state_d  = T1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      req_d = '{write: req_write,
                io:    req_io,
                addr:  BUS_ADDR_W'(req_addr),
                wdata: BUS_DATA_W'(req_wdata)};
    end

    strobe_c    = (state_d inside {T2, T3, TW});
    drive_d     = req_d.write && (state_d inside {T2, T3, TW, T4});
    ale_d       = (state_d == T1);
    iom_d       = req_d.io;
    address_d   = ADDR_W'(req_d.addr);
    rd_n_d      = !(strobe_c && !req_d.write);
    wr_n_d      = !(strobe_c && req_d.write);
    den_n_d     = !strobe_c;
    dtr_d       = drive_d;
    req_ready_d = (state_d == IDLE) || (B2B_EN && state_d == T4);
    rsp_valid_d = (state_d == T4);
    rsp_err_d   = err_c;
    rsp_rdata_d = capture_c ? Data : '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      req_q     <= '0;
      drive_q   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ALE       <= 1'b0;
      IOM       <= IOM_MEM;
      RD_N      <= 1'b1;
      WR_N      <= 1'b1;
      DEN_N     <= 1'b1;
      DTR       <= 1'b0;
      Address   <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      req_q     <= req_d;
      drive_q   <= drive_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      ALE       <= ale_d;
      IOM       <= iom_d;
      RD_N      <= rd_n_d;
      WR_N      <= wr_n_d;
      DEN_N     <= den_n_d;
      DTR       <= dtr_d;
      Address   <= address_d;
    end
  end

  assign Data = drive_q ? DATA_W'(req_q.wdata) : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: a zero-gap instance with a byte
// peripheral model, and an IDLE_GAP=2 instance for the gap timing.
module tb_bus_cycle_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, g_req_valid;
  logic        req_write, req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ready_in;

  logic        req_ready, rsp_valid, rsp_err, ale, iom, rd_n, wr_n, den_n, dtr;
  logic [7:0]  rsp_rdata;
  logic [19:0] addr;
  wire  [7:0]  bus_d;

  logic        g_req_ready, g_rsp_valid, g_rsp_err, g_ale, g_iom, g_rd_n, g_wr_n, g_den_n, g_dtr;
  logic [7:0]  g_rsp_rdata;
  logic [19:0] g_addr;
  wire  [7:0]  g_bus_d;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_cycle_master #(.ADDR_W(20), .DATA_W(8), .IDLE_GAP(0), .MAX_WAIT(15)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(ready_in), .ALE(ale), .IOM(iom), .RD_N(rd_n), .WR_N(wr_n),
    .DEN_N(den_n), .DTR(dtr), .Address(addr), .Data(bus_d)
  );

  bus_cycle_master #(.ADDR_W(20), .DATA_W(8), .IDLE_GAP(2), .MAX_WAIT(15)) dut_gap (
    .CLK(clk), .RESET_N(rst_n),
    .req_valid(g_req_valid), .req_ready(g_req_ready), .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(g_rsp_valid), .rsp_rdata(g_rsp_rdata), .rsp_err(g_rsp_err),
    .READY(ready_in), .ALE(g_ale), .IOM(g_iom), .RD_N(g_rd_n), .WR_N(g_wr_n),
    .DEN_N(g_den_n), .DTR(g_dtr), .Address(g_addr), .Data(g_bus_d)
  );

  // Byte peripheral: latches address on ALE, drives reads, stores writes.
  logic [7:0] mem [0:255];
  logic [7:0] p_addr;

  assign bus_d = (!rd_n && !den_n) ? mem[p_addr] : 8'bz;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      mem[8'h10] <= 8'hA5;
      mem[8'h20] <= 8'h5A;
      p_addr     <= 8'h00;
    end else begin
      if (ale) p_addr <= addr[7:0];
      if (!wr_n) mem[p_addr] <= bus_d;
    end
  end

  task automatic send(input logic w, input logic io, input logic [19:0] a, input logic [7:0] d);
    int k;
    req_write = w; req_io = io; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k == 10) begin
      checks++; errors++;
      $display("FAIL send_timeout: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h err=%b required 0 0 00 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (ale !== 1'b0 || iom !== 1'b0 || rd_n !== 1'b1 || wr_n !== 1'b1 || den_n !== 1'b1 ||
        dtr !== 1'b0 || addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_bus: ale=%b iom=%b rd_n=%b wr_n=%b den_n=%b dtr=%b addr=%h required 0 0 1 1 1 0 00000",
               ale, iom, rd_n, wr_n, den_n, dtr, addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || g_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: ready=%b gap_ready=%b required 1 1", req_ready, g_req_ready);
    end
  endtask

  task automatic test_mem_read();
    send(1'b0, 1'b0, 20'h00010, 8'h00);
    checks++;
    if (ale !== 1'b1 || iom !== 1'b0 || addr !== 20'h00010 || rd_n !== 1'b1) begin
      errors++;
      $display("FAIL read_t1: ale=%b iom=%b addr=%h rd_n=%b required 1 0 00010 1", ale, iom, addr, rd_n);
    end
    @(negedge clk);
    checks++;
    if (ale !== 1'b0 || rd_n !== 1'b0 || den_n !== 1'b0 || dtr !== 1'b0 || wr_n !== 1'b1) begin
      errors++;
      $display("FAIL read_t2: ale=%b rd_n=%b den_n=%b dtr=%b wr_n=%b required 0 0 0 0 1",
               ale, rd_n, den_n, dtr, wr_n);
    end
    @(negedge clk);
    checks++;
    if (rd_n !== 1'b0 || den_n !== 1'b0 || rsp_valid !== 1'b0 || addr !== 20'h00010) begin
      errors++;
      $display("FAIL read_t3: rd_n=%b den_n=%b rsp_valid=%b addr=%h required 0 0 0 00010",
               rd_n, den_n, rsp_valid, addr);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0 || rd_n !== 1'b1 || den_n !== 1'b1) begin
      errors++;
      $display("FAIL read_t4: valid=%b rdata=%h err=%b rd_n=%b den_n=%b required 1 a5 0 1 1",
               rsp_valid, rsp_rdata, rsp_err, rd_n, den_n);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_after: valid=%b rdata=%h ready=%b required 0 00 1", rsp_valid, rsp_rdata, req_ready);
    end
  endtask

  task automatic test_mem_write();
    send(1'b1, 1'b0, 20'h7FFFF, 8'h3C);
    checks++;
    if (ale !== 1'b1 || addr !== 20'h7FFFF || iom !== 1'b0 || wr_n !== 1'b1) begin
      errors++;
      $display("FAIL write_t1: ale=%b addr=%h iom=%b wr_n=%b required 1 7ffff 0 1", ale, addr, iom, wr_n);
    end
    @(negedge clk);
    checks++;
    if (wr_n !== 1'b0 || dtr !== 1'b1 || den_n !== 1'b0 || rd_n !== 1'b1 || bus_d !== 8'h3C) begin
      errors++;
      $display("FAIL write_t2: wr_n=%b dtr=%b den_n=%b rd_n=%b data=%h required 0 1 0 1 3c",
               wr_n, dtr, den_n, rd_n, bus_d);
    end
    @(negedge clk);
    checks++;
    if (wr_n !== 1'b0 || bus_d !== 8'h3C) begin
      errors++;
      $display("FAIL write_t3: wr_n=%b data=%h required 0 3c", wr_n, bus_d);
    end
    @(negedge clk);
    checks++;
    if (wr_n !== 1'b1 || den_n !== 1'b1 || bus_d !== 8'h3C || rsp_valid !== 1'b1 ||
        rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL write_t4: wr_n=%b den_n=%b data=%h valid=%b rdata=%h err=%b required 1 1 3c 1 00 0",
               wr_n, den_n, bus_d, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (dtr !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_after: dtr=%b valid=%b required 0 0", dtr, rsp_valid);
    end
    send(1'b0, 1'b0, 20'h7FFFF, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_readback: valid=%b rdata=%h required 1 3c", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ale_t[4];
    int rsp_t[4];
    logic [7:0] rsp_d[4];
    logic ale_io[4];
    int na, nr;
    na = 0; nr = 0;
    req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00010; req_wdata = 8'h00; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ale === 1'b1 && na < 4) begin
        ale_t[na] = i; ale_io[na] = iom; na++;
        if (na == 1) req_addr = 20'h7FFFF;
        else if (na == 2) begin req_io = 1'b1; req_addr = 20'h00020; end
        else req_valid = 1'b0;
      end
      if (rsp_valid === 1'b1 && nr < 4) begin
        rsp_t[nr] = i; rsp_d[nr] = rsp_rdata; nr++;
      end
    end
    checks++;
    if (na != 3 || nr != 3) begin
      errors++;
      $display("FAIL b2b_count: cycles=%0d responses=%0d required 3 3", na, nr);
    end else begin
      checks++;
      if (rsp_t[1] - rsp_t[0] != 4 || rsp_t[2] - rsp_t[1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: %0d %0d required 4 4", rsp_t[1] - rsp_t[0], rsp_t[2] - rsp_t[1]);
      end
      checks++;
      if (ale_t[1] != rsp_t[0] + 1 || ale_t[2] != rsp_t[1] + 1) begin
        errors++;
        $display("FAIL b2b_t1_after_t4: ale=%0d,%0d rsp=%0d,%0d required ale=rsp+1",
                 ale_t[1], ale_t[2], rsp_t[0], rsp_t[1]);
      end
      checks++;
      if (rsp_d[0] !== 8'hA5 || rsp_d[1] !== 8'h3C || rsp_d[2] !== 8'h5A) begin
        errors++;
        $display("FAIL b2b_data: %h %h %h required a5 3c 5a", rsp_d[0], rsp_d[1], rsp_d[2]);
      end
      checks++;
      if (ale_io[0] !== 1'b0 || ale_io[2] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_iom: %b %b required 0 1", ale_io[0], ale_io[2]);
      end
    end
    req_io = 1'b0;
  endtask

  task automatic test_idle_gap();
    int ale_t[4];
    int rsp_t[4];
    logic rdy[24];
    int na, nr;
    na = 0; nr = 0;
    req_write = 1'b1; req_io = 1'b0; req_addr = 20'h00100; req_wdata = 8'h11; g_req_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rdy[i] = g_req_ready;
      if (i == 1) begin
        checks++;
        if (g_wr_n !== 1'b0 || g_dtr !== 1'b1 || g_den_n !== 1'b0 || g_rd_n !== 1'b1 ||
            g_bus_d !== 8'h11 || g_addr !== 20'h00100 || g_iom !== 1'b0) begin
          errors++;
          $display("FAIL gap_t2: wr_n=%b dtr=%b den_n=%b rd_n=%b data=%h addr=%h iom=%b required 0 1 0 1 11 00100 0",
                   g_wr_n, g_dtr, g_den_n, g_rd_n, g_bus_d, g_addr, g_iom);
        end
      end
      if (g_ale === 1'b1 && na < 4) begin
        ale_t[na] = i; na++;
        if (na == 2) g_req_valid = 1'b0;
      end
      if (g_rsp_valid === 1'b1 && nr < 4) begin
        rsp_t[nr] = i; nr++;
        checks++;
        if (g_rsp_rdata !== 8'h00 || g_rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL gap_rsp: rdata=%h err=%b required 00 0", g_rsp_rdata, g_rsp_err);
        end
      end
    end
    g_req_valid = 1'b0;
    checks++;
    if (na != 2 || nr != 2) begin
      errors++;
      $display("FAIL gap_count: cycles=%0d responses=%0d required 2 2", na, nr);
    end else begin
      // T4, GAP, GAP, IDLE (accept), then T1.
      checks++;
      if (ale_t[1] - rsp_t[0] != 4) begin
        errors++;
        $display("FAIL gap_t4_to_t1: %0d required 4", ale_t[1] - rsp_t[0]);
      end
      checks++;
      if (rdy[rsp_t[0]] !== 1'b0 || rdy[rsp_t[0] + 1] !== 1'b0 || rdy[rsp_t[0] + 2] !== 1'b0 ||
          rdy[rsp_t[0] + 3] !== 1'b1) begin
        errors++;
        $display("FAIL gap_ready: t4=%b gap=%b%b idle=%b required 0 00 1",
                 rdy[rsp_t[0]], rdy[rsp_t[0] + 1], rdy[rsp_t[0] + 2], rdy[rsp_t[0] + 3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    send(1'b0, 1'b0, 20'h00010, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (rd_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: rd_n=%b required 0", rd_n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_n !== 1'b1 || den_n !== 1'b1 || ale !== 1'b0 || rsp_valid !== 1'b0 || addr !== 20'h0 ||
        req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: rd_n=%b den_n=%b ale=%b valid=%b addr=%h ready=%b required 1 1 0 0 00000 0",
               rd_n, den_n, ale, rsp_valid, addr, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || ale === 1'b1 || rd_n === 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_dropped: activity=%0d ready=%b required 0 1", seen, req_ready);
    end
  endtask

`ifdef WAIT_STATE_EN
  task automatic test_wait_states();
    send(1'b0, 1'b0, 20'h00010, 8'h00);
    @(negedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_n !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_tw: rd_n=%b valid=%b required 0 0", rd_n, rsp_valid);
    end
    @(negedge clk);
    ready_in = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_tw3: valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_done: valid=%b rdata=%h err=%b required 1 a5 0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_wait_timeout();
    int k;
    send(1'b0, 1'b0, 20'h00010, 8'h00);
    @(negedge clk);
    @(negedge clk);
    ready_in = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 16 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
      errors++;
      $display("FAIL wait_timeout: cycles_after_t3=%0d err=%b rdata=%h required 16 1 00", k, rsp_err, rsp_rdata);
    end
    ready_in = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wait_timeout_after: valid=%b err=%b required 0 0", rsp_valid, rsp_err);
    end
  endtask
`else
  task automatic test_ready_ignored();
    ready_in = 1'b0;
    send(1'b0, 1'b0, 20'h00020, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL ready_ignored: valid=%b rdata=%h err=%b required 1 5a 0", rsp_valid, rsp_rdata, rsp_err);
    end
    ready_in = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; ready_in = 1'b1;
    req_valid = 1'b0; g_req_valid = 1'b0;
    req_write = 1'b0; req_io = 1'b0; req_addr = 20'h0; req_wdata = 8'h0;
    test_reset();
    test_mem_read();
    test_mem_write();
    test_back_to_back();
    test_idle_gap();
`ifdef WAIT_STATE_EN
    test_wait_states();
    test_wait_timeout();
`else
    test_ready_ignored();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
